// File: rtl/ars_pkg.sv
// Shared types and helpers for the GF(2^233) multiplier arbiter family.
package ars_pkg;

    // Field element width for GF(2^233)
    localparam int unsigned ARS_W       = 233;
    // Largest supported requester count and the flat-bus width it implies
    localparam int unsigned ARS_MAX_REQ = 8;
    localparam int unsigned ARS_FLAT_W  = ARS_MAX_REQ * ARS_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } ars_state_e;

    // Extract slice idx of a flat bus packed at 'width' bits per slice.
    // The caller zero-extends its bus to ARS_FLAT_W; width must not exceed ARS_W.
    function automatic logic [ARS_W-1:0] ars_slice(input logic [ARS_FLAT_W-1:0] flat,
                                                   input int unsigned           width,
                                                   input int unsigned           idx);
        logic [ARS_W-1:0] r_res;
        r_res = '0;
        for (int unsigned k = 0; k < ARS_W; k++) begin
            if (k < width) begin
                r_res[k] = flat[idx * width + k];
            end
        end
        return r_res;
    endfunction

endpackage

// File: rtl/ars_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after i_start.
module ars_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_start,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    localparam int N = int'(NREQ);

    // Walk the requests circularly from i_start and keep the first hit
    always_comb begin
        int pos;
        pos   = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos = int'(i_start) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!o_any && i_req[pos]) begin
                o_any      = 1'b1;
                o_gnt[pos] = 1'b1;
                o_idx      = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/ars_mult_arbiter.sv
// Round-robin sharing of one GF(2^233) multiplier core among NREQ requesters.
// Each requester port keeps the en/rdy handshake of a private multiplier.
module ars_mult_arbiter
    import ars_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = ARS_W,
    parameter int unsigned CNTW = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ*W-1:0] i_a_flat,
    input  logic [NREQ*W-1:0] i_b_flat,
    output logic [NREQ-1:0]   o_rdy,
    output logic [W-1:0]      o_c,
    output logic [NREQ-1:0]   o_gnt,
    output logic [W-1:0]      o_core_a,
    output logic [W-1:0]      o_core_b,
    output logic              o_core_en,
    input  logic              i_core_rdy,
    input  logic [W-1:0]      i_core_c,
    output logic [CNTW-1:0]   o_job_cnt
);

    localparam int unsigned IW = $clog2(NREQ);

    ars_state_e      r_state;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_rdy;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_ptr;
    // Low until the first job ends, so the first search after reset starts at 0
    logic            r_ptr_vld;
    logic [W-1:0]    r_core_a;
    logic [W-1:0]    r_core_b;
    logic            r_core_en;
    logic [W-1:0]    r_c;
    logic [CNTW-1:0] r_job_cnt;

    logic [IW-1:0]         w_start;
    logic [NREQ-1:0]       w_pick_oh;
    logic [IW-1:0]         w_pick_idx;
    logic                  w_pick_any;
    int unsigned           w_pick_sel;
    logic [ARS_FLAT_W-1:0] w_a_ext;
    logic [ARS_FLAT_W-1:0] w_b_ext;
    logic [W-1:0]          w_pick_a;
    logic [W-1:0]          w_pick_b;
    logic                  w_own_req;

    // Search origin: one past the last owner, or 0 straight out of reset
    always_comb begin
        w_start = '0;
        if (r_ptr_vld && (r_ptr != IW'(NREQ - 1))) begin
            w_start = r_ptr + IW'(1);
        end
    end

    ars_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req   (i_req),
        .i_start (w_start),
        .o_gnt   (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_pick_sel = 32'(w_pick_idx);
    assign w_a_ext    = ARS_FLAT_W'(i_a_flat);
    assign w_b_ext    = ARS_FLAT_W'(i_b_flat);
    assign w_pick_a   = W'(ars_slice(w_a_ext, W, w_pick_sel));
    assign w_pick_b   = W'(ars_slice(w_b_ext, W, w_pick_sel));

    // Current owner still requesting; gnt is one-hot so this is a plain mask
    assign w_own_req = |(i_req & r_gnt);

    // Arbiter FSM with all outputs registered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_rdy     <= '0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_ptr_vld <= 1'b0;
            r_core_a  <= '0;
            r_core_b  <= '0;
            r_core_en <= 1'b0;
            r_c       <= '0;
            r_job_cnt <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_gnt     <= w_pick_oh;
                        r_idx     <= w_pick_idx;
                        r_core_a  <= w_pick_a;
                        r_core_b  <= w_pick_b;
                        r_core_en <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A dropped request wins over a simultaneous core_rdy: abort
                    if (!w_own_req) begin
                        r_core_en <= 1'b0;
                        r_gnt     <= '0;
                        r_ptr     <= r_idx;
                        r_ptr_vld <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (i_core_rdy) begin
                        r_c       <= i_core_c;
                        r_rdy     <= r_gnt;
                        r_core_en <= 1'b0;
                        r_job_cnt <= r_job_cnt + CNTW'(1);
                        r_state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!w_own_req) begin
                        r_rdy     <= '0;
                        r_gnt     <= '0;
                        r_ptr     <= r_idx;
                        r_ptr_vld <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rdy     = r_rdy;
    assign o_c       = r_c;
    assign o_gnt     = r_gnt;
    assign o_core_a  = r_core_a;
    assign o_core_b  = r_core_b;
    assign o_core_en = r_core_en;
    assign o_job_cnt = r_job_cnt;

endmodule

// File: tb/tb_ars_mult_arbiter.sv
// Self-checking bench for ars_mult_arbiter: directed scenarios plus randomized traffic
// against a cycle-level behavioural model and a mock multiplier core.
module tb_ars_mult_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 233;
    localparam int CNTW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_flat;
    logic [NREQ*W-1:0] b_flat;
    logic [NREQ-1:0]   rdy;
    logic [W-1:0]      c;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      core_a;
    logic [W-1:0]      core_b;
    logic              core_en;
    logic              core_rdy;
    logic [W-1:0]      core_c;
    logic [CNTW-1:0]   job_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int lat    = 5;
    int mc;

    ars_mult_arbiter #(
        .NREQ (NREQ),
        .W    (W),
        .CNTW (CNTW)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_a_flat   (a_flat),
        .i_b_flat   (b_flat),
        .o_rdy      (rdy),
        .o_c        (c),
        .o_gnt      (gnt),
        .o_core_a   (core_a),
        .o_core_b   (core_b),
        .o_core_en  (core_en),
        .i_core_rdy (core_rdy),
        .i_core_c   (core_c),
        .o_job_cnt  (job_cnt)
    );

    always #5 clk = ~clk;

    // GF(2^233) product, reduction polynomial x^233 + x^74 + 1
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        logic [W-1:0] s;
        logic         top;
        r = '0;
        s = x;
        for (int k = 0; k < W; k++) begin
            if (y[k]) r = r ^ s;
            top = s[W-1];
            s   = {s[W-2:0], 1'b0};
            if (top) begin
                s[74] = ~s[74];
                s[0]  = ~s[0];
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [255:0] t;
        for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom;
        return t[W-1:0];
    endfunction

    function automatic int oh2i(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int k = 0; k < NREQ; k++) if (v[k]) r = k;
        return r;
    endfunction

    // Mock multiplier core: rdy 'lat' enabled cycles after en, clears while en is low
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc       <= 0;
            core_rdy <= 1'b0;
            core_c   <= '0;
        end else if (!core_en) begin
            mc       <= 0;
            core_rdy <= 1'b0;
        end else if (!core_rdy) begin
            if (mc + 1 >= lat) begin
                core_rdy <= 1'b1;
                core_c   <= gf_mul(core_a, core_b);
            end
            mc <= mc + 1;
        end
    end

    // ---------------- behavioural model ----------------
    int              m_owner;  // -1 when the core is free
    bit              m_hold;   // owner has its result
    int              m_ptr;
    bit              m_vld;
    logic [NREQ-1:0] e_gnt;
    logic [NREQ-1:0] e_rdy;
    logic            e_en;
    logic [W-1:0]    e_c;
    logic [W-1:0]    e_a;
    logic [W-1:0]    e_b;
    logic [CNTW-1:0] e_cnt;

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
        m_vld   = 0;
        e_gnt   = '0;
        e_rdy   = '0;
        e_en    = 1'b0;
        e_c     = '0;
        e_a     = '0;
        e_b     = '0;
        e_cnt   = '0;
    endtask

    // Advance the model by one clock using the inputs present before the edge
    task automatic model_step();
        int  start;
        int  j;
        bit  found;
        if (m_owner < 0) begin
            start = m_vld ? (m_ptr + 1) % NREQ : 0;
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                j = (start + k) % NREQ;
                if (!found && req[j]) begin
                    found    = 1;
                    m_owner  = j;
                    m_hold   = 0;
                    e_gnt    = '0;
                    e_gnt[j] = 1'b1;
                    e_en     = 1'b1;
                    e_a      = a_flat[j*W +: W];
                    e_b      = b_flat[j*W +: W];
                end
            end
        end else if (!req[m_owner]) begin
            e_rdy   = '0;
            e_gnt   = '0;
            e_en    = 1'b0;
            m_ptr   = m_owner;
            m_vld   = 1;
            m_owner = -1;
        end else if (!m_hold && core_rdy) begin
            e_c            = gf_mul(e_a, e_b);
            e_rdy          = '0;
            e_rdy[m_owner] = 1'b1;
            e_en           = 1'b0;
            e_cnt          = e_cnt + 1'b1;
            m_hold         = 1;
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic compare();
        check("gnt",     W'(gnt),     W'(e_gnt));
        check("rdy",     W'(rdy),     W'(e_rdy));
        check("core_en", W'(core_en), W'(e_en));
        check("c",       c,           e_c);
        check("job_cnt", W'(job_cnt), W'(e_cnt));
        check("core_a",  core_a,      e_a);
        check("core_b",  core_b,      e_b);
    endtask

    // One clock: model step, edge, then compare on the falling edge
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_flat[i*W +: W] = a;
        b_flat[i*W +: W] = b;
    endtask

    task automatic wait_rdy(input int who, input int limit);
        int n;
        n = 0;
        while (!rdy[who] && n < limit) begin
            cycle();
            n++;
        end
        check("wait_rdy", W'(rdy[who]), W'(1));
    endtask

    initial begin
        int              order[$];
        int              exp_ord[6];
        int              dones;
        logic [NREQ-1:0] prev_gnt;
        logic [NREQ-1:0] dropped;
        int              n;

        exp_ord = '{0, 1, 2, 3, 0, 1};
        rst_n   = 1'b0;
        req     = '0;
        a_flat  = '0;
        b_flat  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_gnt", W'(gnt), W'(0));
        check("reset_rdy", W'(rdy), W'(0));
        check("reset_en",  W'(core_en), W'(0));
        check("reset_cnt", W'(job_cnt), W'(0));
        rst_n = 1'b1;

        // Contention: everyone requests, drops on rdy and re-raises a cycle later
        lat = 2;
        for (int i = 0; i < NREQ; i++) set_op(i, rand_w(), rand_w());
        req      = '1;
        dones    = 0;
        prev_gnt = '0;
        dropped  = '0;
        for (int t = 0; t < 300 && dones < 6; t++) begin
            cycle();
            if (gnt != 0 && prev_gnt == 0) order.push_back(oh2i(gnt));
            prev_gnt = gnt;
            req      = req | dropped;
            dropped  = '0;
            if (rdy != 0) begin
                dones++;
                dropped = rdy;
                req     = req & ~rdy;
            end
        end
        check("contention_jobs", W'(dones), W'(6));
        for (int k = 0; k < 6; k++) begin
            check("grant_order", W'(k < order.size() ? order[k] : -1), W'(exp_ord[k]));
        end
        req = '0;
        repeat (2) cycle();

        // Single job, core latency 5
        set_op(0, W'(2), W'(3));
        lat = 5;
        req = 4'b0001;
        cycle();
        check("t1_gnt", W'(gnt), W'(4'b0001));
        check("t1_en",  W'(core_en), W'(1));
        repeat (5) cycle();
        check("t1_rdy_c6", W'(rdy), W'(0));
        cycle();
        check("t1_rdy", W'(rdy), W'(4'b0001));
        check("t1_c",   c, W'(6));
        check("t1_cnt", W'(job_cnt), W'(7));
        req = '0;
        cycle();
        check("t1_rel_rdy", W'(rdy), W'(0));
        check("t1_rel_gnt", W'(gnt), W'(0));

        // Abort of requester 2, requester 3 pending
        set_op(2, W'(3), W'(3));
        set_op(3, W'(3), W'(3));
        req = 4'b1100;
        cycle();
        check("ab_gnt2", W'(gnt), W'(4'b0100));
        repeat (2) cycle();
        req[2] = 1'b0;
        cycle();
        check("ab_gnt0", W'(gnt), W'(0));
        check("ab_rdy",  W'(rdy), W'(0));
        check("ab_cnt",  W'(job_cnt), W'(7));
        cycle();
        check("ab_gnt3", W'(gnt), W'(4'b1000));
        wait_rdy(3, 20);
        check("ab_c", c, W'(5));
        check("ab_cnt2", W'(job_cnt), W'(8));
        req = '0;
        cycle();

        // Abort colliding with core_rdy
        set_op(1, W'(9), W'(6));
        lat = 3;
        req = 4'b0010;
        n   = 0;
        while (!core_rdy && n < 20) begin
            cycle();
            n++;
        end
        check("col_core_rdy", W'(core_rdy), W'(1));
        req[1] = 1'b0;
        cycle();
        check("col_rdy", W'(rdy), W'(0));
        check("col_gnt", W'(gnt), W'(0));
        check("col_cnt", W'(job_cnt), W'(8));
        cycle();
        check("col_idle", W'(gnt), W'(0));

        // Operand change after grant has no effect
        set_op(0, W'(5), W'(7));
        lat = 4;
        req = 4'b0001;
        cycle();
        check("op_core_a", core_a, W'(5));
        set_op(0, rand_w(), rand_w());
        wait_rdy(0, 20);
        check("op_c", c, W'('h1b));
        check("op_cnt", W'(job_cnt), W'(9));
        req = '0;
        cycle();

        // Asynchronous reset in the middle of a job
        set_op(2, rand_w(), rand_w());
        lat = 6;
        req = 4'b0100;
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1;
        check("ar_en",  W'(core_en), W'(0));
        check("ar_gnt", W'(gnt), W'(0));
        check("ar_rdy", W'(rdy), W'(0));
        check("ar_cnt", W'(job_cnt), W'(0));
        model_reset();
        req = 4'b0010;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("ar_gnt1", W'(gnt), W'(4'b0010));
        wait_rdy(1, 20);
        req = '0;
        cycle();

        // Randomized traffic against the model
        for (int t = 0; t < 3000; t++) begin
            if (!core_en && !core_rdy) lat = $urandom_range(1, 6);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (rdy[i]) begin
                        if ($urandom_range(0, 2) != 0) req[i] = 1'b0;
                    end else begin
                        if ($urandom_range(0, 59) == 0) req[i] = 1'b0;
                        if ($urandom_range(0, 7) == 0) set_op(i, rand_w(), rand_w());
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    set_op(i, rand_w(), rand_w());
                    req[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1 compare();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
